// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin tri-state bus arbiter with break-before-make dead time and hold timeout
module tribus_arbiter #(
    parameter int N           = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int MAX_HOLD    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         en,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 bus_busy,
    output logic                 timeout
);
    localparam int IW = $clog2(N);
    localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
    localparam int DW = DEAD_CYCLES > 0 ? $clog2(DEAD_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, GRANT, DEAD} state_t;
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   nxt_ptr;
    logic [HW-1:0]   hold;
    logic [DW-1:0]   dead;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    logic            rel;
    logic            expire;
    // rotate req so bit 0 is the pointer position, then take the lowest set bit
    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[N-1:0];
        sel     = ptr;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) sel = IW'((int'(ptr) + i) % N);
        nxt_ptr = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
        rel     = !req[gnt_id];
        expire  = (MAX_HOLD != 0) && (hold == HW'(MAX_HOLD));
    end
    // grant / release / dead-time sequencing with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            en       <= '0;
            gnt_id   <= '0;
            bus_busy <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold     <= '0;
            dead     <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE:
                    if (|req) begin
                        en       <= N'(1) << sel;
                        gnt_id   <= sel;
                        bus_busy <= 1'b1;
                        hold     <= HW'(1);
                        state    <= GRANT;
                    end
                GRANT:
                    if (rel || expire) begin
                        en       <= '0;
                        bus_busy <= 1'b0;
                        timeout  <= !rel;
                        ptr      <= nxt_ptr;
                        dead     <= '0;
                        state    <= (DEAD_CYCLES == 0) ? IDLE : DEAD;
                    end else if (MAX_HOLD != 0) begin
                        hold <= hold + 1'b1;
                    end
                DEAD:
                    if (dead == DW'(DEAD_CYCLES - 1)) begin
                        dead  <= '0;
                        state <= IDLE;
                    end else begin
                        dead <= dead + 1'b1;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tribus_arbiter.sv
// tb_tribus_arbiter: directed and random checks of tribus_arbiter against a grant-history model
module tb_tribus_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req0 = '0, req1 = '0;
    logic [3:0] en0, en1;
    logic [1:0] gid0, gid1;
    logic       busy0, busy1, to0, to1;
    int tests = 0, fails = 0;
    int D[2]  = '{2, 0};
    int MH[2] = '{8, 0};
    int m_own[2], m_held[2], m_since[2], m_ptr[2], m_gid[2];
    logic m_to[2];

    tribus_arbiter #(.N(4), .DEAD_CYCLES(2), .MAX_HOLD(8)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .en(en0), .gnt_id(gid0), .bus_busy(busy0), .timeout(to0));
    tribus_arbiter #(.N(4), .DEAD_CYCLES(0), .MAX_HOLD(0)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .en(en1), .gnt_id(gid1), .bus_busy(busy1), .timeout(to1));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_held[k] = 0; m_since[k] = D[k] + 1;
            m_ptr[k] = 0; m_gid[k] = 0; m_to[k] = 1'b0;
        end
    endtask

    // one clock edge of the bus rules: owner keeps bus until it drops req or
    // exhausts its hold budget; a new owner only after DEAD+1 idle edges
    task automatic model_step(int k, logic [3:0] r);
        m_to[k] = 1'b0;
        if (m_own[k] >= 0) begin
            if (!r[m_own[k]] || (MH[k] != 0 && m_held[k] == MH[k])) begin
                m_to[k]   = r[m_own[k]];
                m_ptr[k]  = (m_own[k] + 1) % 4;
                m_own[k]  = -1;
                m_since[k] = 0;
            end else begin
                m_held[k]++;
            end
        end else begin
            if (m_since[k] < 100) m_since[k]++;
            if (m_since[k] > D[k] && r != 0) begin
                for (int i = 0; i < 4; i++) begin
                    int c = (m_ptr[k] + i) % 4;
                    if (r[c] && m_own[k] < 0) begin
                        m_own[k] = c; m_gid[k] = c; m_held[k] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_dut(int k);
        logic [3:0] e, x;
        logic [1:0] g;
        logic b, t;
        e = k ? en1 : en0;
        g = k ? gid1 : gid0;
        b = k ? busy1 : busy0;
        t = k ? to1 : to0;
        x = m_own[k] >= 0 ? 4'(1 << m_own[k]) : 4'b0;
        chk($sformatf("en%0d", k), 32'(e), 32'(x));
        chk($sformatf("busy%0d", k), 32'(b), 32'(m_own[k] >= 0));
        chk($sformatf("gnt_id%0d", k), 32'(g), 32'(m_gid[k]));
        chk($sformatf("timeout%0d", k), 32'(t), 32'(m_to[k]));
        chk($sformatf("onehot%0d", k), 32'($onehot0(e)), 32'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_step(0, req0);
            model_step(1, req1);
        end
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int gap, run, tos;
        bit seen;
        logic [1:0] order[$];
        logic [3:0] prev;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_dut(0);
        check_dut(1);

        // single request, released after 3 grant cycles
        req0 = 4'b0100;
        tick();
        chk("s1_en", 32'(en0), 32'h4);
        chk("s1_gid", 32'(gid0), 32'd2);
        tick(); tick();
        req0 = 4'b0000;
        tick();
        chk("s1_release", 32'({en0, busy0}), 32'h0);
        repeat (4) tick();

        // all request, each owner drops after 2 grant cycles
        do_reset();
        gap = 0; seen = 0; prev = '0;
        for (int c = 0; c < 40; c++) begin
            req0 = 4'hF;
            if (m_own[0] >= 0 && m_held[0] == 2) req0[m_own[0]] = 1'b0;
            tick();
            if (en0 != 0 && prev == 0) begin
                order.push_back(gid0);
                if (seen) chk("s2_gap", 32'(gap), 32'd3);
                seen = 1;
            end
            gap  = (en0 == 0) ? gap + 1 : 0;
            prev = en0;
        end
        chk("s2_grants", 32'(order.size() >= 6), 32'd1);
        foreach (order[i]) chk("s2_order", 32'(order[i]), 32'(i % 4));

        // lone requester hitting the hold timeout repeatedly
        do_reset();
        req0 = 4'b0010; run = 0; tos = 0;
        for (int c = 0; c < 36; c++) begin
            tick();
            if (to0) tos++;
            if (en0[1]) run++;
            else if (run != 0) begin
                chk("s3_run", 32'(run), 32'd8);
                run = 0;
            end
        end
        chk("s3_timeouts", 32'(tos), 32'd3);

        // late request waits, pulse during dead time is lost
        req0 = 4'b0000;
        do_reset();
        req0 = 4'b0001; tick(); tick();
        req0 = 4'b1001; tick(); tick();
        req0 = 4'b1000; tick();
        req0 = 4'b1100; tick();
        req0 = 4'b1000; tick(); tick();
        chk("s4_en", 32'(en0), 32'h8);
        tick();

        // asynchronous reset mid-grant, then regrant
        #2 rst = 1'b1;
        #1;
        chk("s5_async_en", 32'(en0), 32'h0);
        chk("s5_async_busy", 32'(busy0), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("s5_regrant", 32'(en0), 32'h8);

        // no timeout, no dead time instance
        req0 = 4'b0000;
        req1 = 4'b0011;
        repeat (30) tick();
        chk("s6_hold", 32'(en1), 32'h1);
        req1 = 4'b0010;
        tick();
        chk("s6_gap", 32'(en1), 32'h0);
        tick();
        chk("s6_switch", 32'(en1), 32'h2);

        // random traffic, slowly toggling requests
        for (int c = 0; c < 400; c++) begin
            req0 = req0 ^ 4'($urandom & $urandom);
            req1 = req1 ^ 4'($urandom & $urandom & $urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
